// File: rtl/rf_dbg_port.sv
// rf_dbg_port: single-word debug read/write responder for the GPR file.
// Reads sample the RF through a private read port; writes borrow idle WB slots.
module rf_dbg_port #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic        s_dbg_req_i,
   input  logic        s_dbg_we_i,
   input  logic [4:0]  s_dbg_add_i,
   input  logic [31:0] s_dbg_wdata_i,
   output logic        s_dbg_ack_o,
   output logic [31:0] s_dbg_rdata_o,
   output logic        s_dbg_err_o,
   input  logic        s_halted_i,
   input  logic        s_wb_we_i,
   input  logic [4:0]  s_wb_add_i,
   input  logic [31:0] s_wb_val_i,
   output logic [4:0]  s_rf_radd_o,
   input  logic [31:0] s_rf_rval_i,
   output logic        s_rf_we_o,
   output logic [4:0]  s_rf_wadd_o,
   output logic [31:0] s_rf_wval_o
);

   localparam int unsigned     CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } state_t;

   state_t        r_state;
   logic [4:0]    r_add;
   logic [31:0]   r_wdata;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic          r_ack;

   logic          w_wb_hit;

   assign w_wb_hit = s_wb_we_i && (s_wb_add_i == r_add);

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         r_state <= ST_IDLE;
         r_add   <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (s_dbg_req_i) begin
                  r_add   <= s_dbg_add_i;
                  r_wdata <= s_dbg_wdata_i;
                  r_cnt   <= '0;
                  if (!s_halted_i) begin
                     r_err   <= 1'b1;
                     r_ack   <= 1'b1;
                     r_state <= ST_RESP;
                  end else if (s_dbg_we_i) begin
                     r_state <= ST_WRITE;
                  end else begin
                     r_state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               // a WB write landing in this same cycle is newer than the RF array
               if (r_add == '0)
                  r_rdata <= '0;
               else if (w_wb_hit)
                  r_rdata <= s_wb_val_i;
               else
                  r_rdata <= s_rf_rval_i;
               r_err   <= 1'b0;
               r_ack   <= 1'b1;
               r_state <= ST_RESP;
            end
            ST_WRITE: begin
               if (!s_wb_we_i) begin
                  r_err   <= 1'b0;
                  r_ack   <= 1'b1;
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == C_LAST) begin
                     r_err   <= 1'b1;
                     r_ack   <= 1'b1;
                     r_state <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // reset gating keeps an aborted write from reaching the RF in the reset cycle
   assign s_rf_we_o     = (r_state == ST_WRITE) && (r_add != '0) && !s_wb_we_i && !s_reset_i;
   assign s_rf_wadd_o   = r_add;
   assign s_rf_wval_o   = r_wdata;
   assign s_rf_radd_o   = r_add;
   assign s_dbg_ack_o   = r_ack;
   assign s_dbg_rdata_o = r_rdata;
   assign s_dbg_err_o   = r_err;

endmodule

// File: tb/tb_rf_dbg_port.sv
// Bench for rf_dbg_port: transaction-level model predicts ack/strobe cycles,
// error flag, read data and latched address; outputs compared every cycle.
module tb_rf_dbg_port;

   localparam int unsigned TIMEOUT = 15;
   localparam int unsigned NONE    = 32'hFFFF_FFFF;

   logic        s_clk_i = 1'b0;
   logic        s_reset_i;
   logic        s_dbg_req_i;
   logic        s_dbg_we_i;
   logic [4:0]  s_dbg_add_i;
   logic [31:0] s_dbg_wdata_i;
   logic        s_dbg_ack_o;
   logic [31:0] s_dbg_rdata_o;
   logic        s_dbg_err_o;
   logic        s_halted_i;
   logic        s_wb_we_i;
   logic [4:0]  s_wb_add_i;
   logic [31:0] s_wb_val_i;
   logic [4:0]  s_rf_radd_o;
   logic [31:0] s_rf_rval_i;
   logic        s_rf_we_o;
   logic [4:0]  s_rf_wadd_o;
   logic [31:0] s_rf_wval_o;

   rf_dbg_port #(.TIMEOUT(TIMEOUT)) dut (
      .s_clk_i       (s_clk_i),
      .s_reset_i     (s_reset_i),
      .s_dbg_req_i   (s_dbg_req_i),
      .s_dbg_we_i    (s_dbg_we_i),
      .s_dbg_add_i   (s_dbg_add_i),
      .s_dbg_wdata_i (s_dbg_wdata_i),
      .s_dbg_ack_o   (s_dbg_ack_o),
      .s_dbg_rdata_o (s_dbg_rdata_o),
      .s_dbg_err_o   (s_dbg_err_o),
      .s_halted_i    (s_halted_i),
      .s_wb_we_i     (s_wb_we_i),
      .s_wb_add_i    (s_wb_add_i),
      .s_wb_val_i    (s_wb_val_i),
      .s_rf_radd_o   (s_rf_radd_o),
      .s_rf_rval_i   (s_rf_rval_i),
      .s_rf_we_o     (s_rf_we_o),
      .s_rf_wadd_o   (s_rf_wadd_o),
      .s_rf_wval_o   (s_rf_wval_o)
   );

   always #5 s_clk_i = ~s_clk_i;

   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;

   // expected behaviour, set by the driver ahead of each cycle
   logic        chk_en = 1'b0;
   int unsigned ack_cyc = NONE;
   int unsigned we_cyc = NONE;
   logic        exp_err = 1'b0;
   logic [31:0] exp_rdata = '0;
   logic [4:0]  cur_add = '0;
   logic [31:0] cur_wdata = '0;
   int unsigned c0 = 0;
   logic        rnd_wb = 1'b0;

   // observations for literal directed checks
   int unsigned obs_ack_cyc = NONE;
   logic        obs_err = 1'b0;
   int unsigned obs_we_n = 0;
   int unsigned obs_we_first = NONE;
   logic [31:0] obs_wval = '0;

   // register file environment and the model's view of it
   logic        rf_clr;
   logic [31:0] env_rf [32];
   logic [31:0] mdl [32];

   assign s_rf_rval_i = env_rf[s_rf_radd_o];

   always @(posedge s_clk_i) begin
      cyc <= cyc + 1;
      if (rf_clr) begin
         for (int i = 0; i < 32; i++) env_rf[i] <= (i == 0) ? 32'hA5A5_A5A5 : 32'h0;
      end else begin
         if (s_wb_we_i && s_wb_add_i != 5'd0) env_rf[s_wb_add_i] <= s_wb_val_i;
         if (s_rf_we_o) env_rf[s_rf_wadd_o] <= s_rf_wval_o;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge s_clk_i) begin
      if (chk_en) begin
         chk("ack", {31'b0, s_dbg_ack_o}, {31'b0, cyc == ack_cyc});
         chk("rf_we", {31'b0, s_rf_we_o}, {31'b0, cyc == we_cyc});
         chk("we_wb_clash", {31'b0, s_rf_we_o & s_wb_we_i}, 32'h0);
         chk("radd", {27'b0, s_rf_radd_o}, {27'b0, cur_add});
         chk("wadd", {27'b0, s_rf_wadd_o}, {27'b0, cur_add});
         chk("wval", s_rf_wval_o, cur_wdata);
         chk("rdata", s_dbg_rdata_o, exp_rdata);
         if (cyc == ack_cyc) chk("err", {31'b0, s_dbg_err_o}, {31'b0, exp_err});
         if (s_dbg_ack_o) begin
            obs_ack_cyc = cyc;
            obs_err     = s_dbg_err_o;
         end
         if (s_rf_we_o) begin
            if (obs_we_n == 0) begin
               obs_we_first = cyc;
               obs_wval     = s_rf_wval_o;
            end
            obs_we_n++;
         end
      end
   end

   task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] v);
      s_wb_we_i  = we;
      s_wb_add_i = a;
      s_wb_val_i = v;
      if (we && a != 5'd0) mdl[a] = v;
   endtask

   task automatic wb_rand();
      if (rnd_wb) wb($urandom_range(0, 1) == 1, 5'($urandom), $urandom);
      else wb(1'b0, 5'd0, 32'h0);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         s_dbg_req_i = 1'b0;
         wb_rand();
         @(posedge s_clk_i); #1;
      end
      wb(1'b0, 5'd0, 32'h0);
   endtask

   // One debug transaction; the expected ack/strobe cycles follow directly from
   // the stated latencies: not halted 1, read 2, write 2+busy, timeout 1+TIMEOUT.
   task automatic do_txn(input logic h, input logic w, input logic [4:0] a, input logic [31:0] d,
                         input int unsigned nbusy, input logic drop,
                         input logic rwe, input logic [4:0] radd, input logic [31:0] rval);
      logic [31:0] pend;
      logic        last;
      c0   = cyc;
      pend = exp_rdata;
      s_dbg_req_i   = 1'b1;
      s_dbg_we_i    = w;
      s_dbg_add_i   = a;
      s_dbg_wdata_i = d;
      s_halted_i    = h;
      wb_rand();
      we_cyc  = NONE;
      exp_err = 1'b0;
      if (!h) begin
         ack_cyc = c0 + 1;
         exp_err = 1'b1;
      end else if (!w) begin
         ack_cyc = c0 + 2;
      end else if (nbusy >= TIMEOUT) begin
         ack_cyc = c0 + 1 + TIMEOUT;
         exp_err = 1'b1;
      end else begin
         ack_cyc = c0 + 2 + nbusy;
         if (a != 5'd0) we_cyc = c0 + 1 + nbusy;
      end
      obs_we_n     = 0;
      obs_we_first = NONE;
      obs_ack_cyc  = NONE;
      @(posedge s_clk_i); #1;
      cur_add   = a;
      cur_wdata = d;
      if (drop) begin
         s_dbg_req_i   = 1'b0;
         s_dbg_we_i    = 1'($urandom);
         s_dbg_add_i   = 5'($urandom);
         s_dbg_wdata_i = $urandom;
      end
      if (h) s_halted_i = $urandom_range(0, 1) == 1;
      do begin
         last = (cyc == ack_cyc);
         if (last) begin
            if (h && !w) exp_rdata = pend;
            wb_rand();
         end else if (!w) begin
            pend = (a == 5'd0) ? 32'h0 : (rwe && radd == a) ? rval : mdl[a];
            wb(rwe, radd, rval);
         end else if (cyc - c0 <= nbusy) begin
            wb(1'b1, rnd_wb ? 5'($urandom) : 5'd31, $urandom);
         end else begin
            wb(1'b0, 5'd0, 32'h0);
         end
         if (cyc == we_cyc) mdl[a] = d;
         @(posedge s_clk_i); #1;
      end while (!last);
      s_dbg_req_i = 1'b0;
      wb(1'b0, 5'd0, 32'h0);
   endtask

   task automatic reset_mid_write();
      c0 = cyc;
      s_dbg_req_i   = 1'b1;
      s_dbg_we_i    = 1'b1;
      s_dbg_add_i   = 5'd9;
      s_dbg_wdata_i = 32'h0BAD_F00D;
      s_halted_i    = 1'b1;
      wb(1'b0, 5'd0, 32'h0);
      ack_cyc = NONE;
      we_cyc  = NONE;
      obs_we_n    = 0;
      obs_ack_cyc = NONE;
      @(posedge s_clk_i); #1;
      cur_add     = 5'd9;
      cur_wdata   = 32'h0BAD_F00D;
      s_dbg_req_i = 1'b0;
      s_reset_i   = 1'b1;
      @(posedge s_clk_i); #1;
      s_reset_i = 1'b0;
      cur_add   = '0;
      cur_wdata = '0;
      exp_rdata = '0;
      chk("rst_ack", {31'b0, s_dbg_ack_o}, 32'h0);
      chk("rst_rdata", s_dbg_rdata_o, 32'h0);
      chk("rst_err", {31'b0, s_dbg_err_o}, 32'h0);
      chk("rst_wadd", {27'b0, s_rf_wadd_o}, 32'h0);
      chk("rst_wval", s_rf_wval_o, 32'h0);
      idle(2);
      chk("rst_no_we", obs_we_n, 0);
      chk("rst_no_ack", obs_ack_cyc, NONE);
   endtask

   initial begin
      int unsigned nb;
      logic        rw;
      logic [4:0]  ra;
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      s_reset_i = 1'b1;
      rf_clr    = 1'b1;
      s_dbg_req_i = 1'b0; s_dbg_we_i = 1'b0; s_dbg_add_i = '0; s_dbg_wdata_i = '0;
      s_halted_i = 1'b0;
      wb(1'b0, 5'd0, 32'h0);
      repeat (3) @(posedge s_clk_i);
      #1;
      s_reset_i = 1'b0;
      rf_clr    = 1'b0;
      chk("reset_ack", {31'b0, s_dbg_ack_o}, 32'h0);
      chk("reset_rdata", s_dbg_rdata_o, 32'h0);
      chk("reset_err", {31'b0, s_dbg_err_o}, 32'h0);
      chk("reset_rf_we", {31'b0, s_rf_we_o}, 32'h0);
      chk("reset_wadd", {27'b0, s_rf_wadd_o}, 32'h0);
      chk("reset_wval", s_rf_wval_o, 32'h0);
      chk_en = 1'b1;
      idle(1);

      // write x5, WB idle
      do_txn(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("wr5_we_lat", obs_we_first - c0, 1);
      chk("wr5_wval", obs_wval, 32'hDEAD_BEEF);
      chk("wr5_ack_lat", obs_ack_cyc - c0, 2);
      chk("wr5_err", {31'b0, obs_err}, 32'h0);
      idle(1);
      do_txn(1'b1, 1'b0, 5'd5, 32'h0, 0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("rd5_data", s_dbg_rdata_o, 32'hDEAD_BEEF);
      chk("rd5_ack_lat", obs_ack_cyc - c0, 2);

      // read x7 with WB to x8, then with WB to x7 in the READ cycle
      do_txn(1'b1, 1'b0, 5'd7, 32'h0, 0, 1'b0, 1'b1, 5'd8, 32'hCAFE_F00D);
      chk("rd7_nohit", s_dbg_rdata_o, 32'h0);
      do_txn(1'b1, 1'b0, 5'd7, 32'h0, 0, 1'b0, 1'b1, 5'd7, 32'h1234_5678);
      chk("rd7_fwd", s_dbg_rdata_o, 32'h1234_5678);

      // write x3 with WB busy 4, then busy past the timeout
      do_txn(1'b1, 1'b1, 5'd3, 32'h3333_0003, 4, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("wr3_we_lat", obs_we_first - c0, 5);
      chk("wr3_ack_lat", obs_ack_cyc - c0, 6);
      chk("wr3_err", {31'b0, obs_err}, 32'h0);
      do_txn(1'b1, 1'b1, 5'd3, 32'h3333_1003, 20, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("to_ack_lat", obs_ack_cyc - c0, 16);
      chk("to_err", {31'b0, obs_err}, 32'h1);
      chk("to_we_n", obs_we_n, 0);

      // not halted: immediate error, rdata retained
      do_txn(1'b0, 1'b0, 5'd5, 32'h0, 0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("nh_ack_lat", obs_ack_cyc - c0, 1);
      chk("nh_err", {31'b0, obs_err}, 32'h1);
      chk("nh_rdata", s_dbg_rdata_o, 32'h1234_5678);

      // x0 write is a no-op, x0 read is zero even against a forwarding WB
      do_txn(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("wr0_ack_lat", obs_ack_cyc - c0, 2);
      chk("wr0_err", {31'b0, obs_err}, 32'h0);
      chk("wr0_we_n", obs_we_n, 0);
      do_txn(1'b1, 1'b0, 5'd0, 32'h0, 0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      chk("rd0_data", s_dbg_rdata_o, 32'h0);

      // request dropped after acceptance, then back-to-back reads
      do_txn(1'b1, 1'b0, 5'd5, 32'h0, 0, 1'b1, 1'b0, 5'd0, 32'h0);
      chk("drop_ack_lat", obs_ack_cyc - c0, 2);
      chk("drop_rdata", s_dbg_rdata_o, 32'hDEAD_BEEF);
      do_txn(1'b1, 1'b0, 5'd7, 32'h0, 0, 1'b0, 1'b0, 5'd0, 32'h0);
      do_txn(1'b1, 1'b0, 5'd3, 32'h0, 0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("b2b_rdata", s_dbg_rdata_o, 32'h3333_0003);

      reset_mid_write();

      // randomized traffic
      rnd_wb = 1'b1;
      for (int n = 0; n < 250; n++) begin
         case ($urandom_range(0, 9))
            0:       nb = TIMEOUT + $urandom_range(0, 2);
            1, 2, 3: nb = $urandom_range(1, TIMEOUT - 1);
            default: nb = 0;
         endcase
         rw = $urandom_range(0, 1) == 1;
         ra = 5'($urandom);
         do_txn($urandom_range(0, 7) != 0, rw, ra, $urandom, nb, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? ra : 5'($urandom), $urandom);
         idle($urandom_range(0, 2));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule

// File: doc/rf_dbg_port.md
# rf_dbg_port

Debug access responder for the general-purpose register file: services single-word read/write requests from the debug module while the core is halted. Reads sample the RF through a dedicated read address port; writes are injected into the RF write port in cycles where the write-back stage does not write. Sits beside the register-file write controller and feeds its write mux with an alternative write source.

## Interface
- TIMEOUT, 15, max cycles a debug write waits for a free write slot before aborting with error (>= 1)
- s_clk_i  in  1  clock
- s_reset_i  in  1  synchronous reset, active-high
- s_dbg_req_i  in  1  debug request, level, held until ack
- s_dbg_we_i  in  1  1 = write, 0 = read; sampled with req
- s_dbg_add_i  in  5  GPR address; sampled with req
- s_dbg_wdata_i  in  32  write data; sampled with req
- s_dbg_ack_o  out  1  one-cycle response pulse
- s_dbg_rdata_o  out  32  read data, valid with ack, holds until next response
- s_dbg_err_o  out  1  error flag, valid only with ack
- s_halted_i  in  1  core halted
- s_wb_we_i  in  1  WB stage writes RF this cycle
- s_wb_add_i  in  5  WB destination address
- s_wb_val_i  in  32  WB write value
- s_rf_radd_o  out  5  RF read address (combinational read returns s_rf_rval_i same cycle)
- s_rf_rval_i  in  32  RF read value
- s_rf_we_o  out  1  debug write strobe into RF write mux
- s_rf_wadd_o  out  5  debug write address
- s_rf_wval_o  out  32  debug write value

## Operation
- States: IDLE, READ, WRITE, RESP. Registers: latched we/add/wdata, wait counter ($clog2(TIMEOUT+1) bits), rdata, err.
- IDLE: on s_dbg_req_i=1 latch we/add/wdata. If s_halted_i=0 -> RESP with err=1, rdata unchanged. Else we=0 -> READ, we=1 -> WRITE; counter cleared.
- READ (one cycle): s_rf_radd_o = latched add. Captured value: 0 if add=0; else s_wb_val_i if s_wb_we_i=1 and s_wb_add_i=add (forwarding of concurrent WB write); else s_rf_rval_i. -> RESP, err=0.
- WRITE: s_rf_we_o = (add!=0) & ~s_wb_we_i, combinational from state. If s_wb_we_i=0 -> RESP, err=0 (add=0 completes with no RF write). If s_wb_we_i=1: counter+1; when counter reaches TIMEOUT -> RESP, err=1, no write performed.
- RESP: s_dbg_ack_o=1 for exactly one cycle -> IDLE.
- s_rf_wadd_o/s_rf_wval_o = latched add/wdata at all times; s_rf_we_o never asserted outside WRITE and never coincident with s_wb_we_i=1.
- s_rf_radd_o = latched add in all states.
- Requester dropping req before ack: transaction still completes and acks; a new request is accepted only in IDLE, so earliest re-accept is the cycle after ack.
- s_halted_i dropping during READ/WRITE: in-progress access completes normally.

## Timing
- Reset (sync, s_reset_i=1 at clock edge): state IDLE, counter 0, s_dbg_ack_o=0, s_dbg_rdata_o=0, s_dbg_err_o=0, s_rf_we_o=0, latched add/wdata=0. Reset mid-operation aborts: no ack, no RF write.
- Read: req sampled cycle 0 -> READ cycle 1 -> ack cycle 2.
- Write, free slot: accept cycle 0 -> s_rf_we_o cycle 1 -> ack cycle 2.
- Write with WB busy N cycles (N < TIMEOUT): s_rf_we_o cycle 1+N, ack cycle 2+N.
- Write timeout: WB busy TIMEOUT consecutive WRITE cycles -> ack with err=1 in cycle 1+TIMEOUT.
- Not halted: ack with err=1 in cycle 1.
- Back-to-back requests: minimum 3 cycles per read, i.e. ack at 2, next accept at 3.

## Test plan
- Halted, write x5=0xDEADBEEF with WB idle -> s_rf_we_o=1 cycle 1 with wadd=5, wval=0xDEADBEEF; ack cycle 2, err=0; subsequent read x5 -> rdata=0xDEADBEEF ack at +2.
- Read x7 while WB writes x7=0x12345678 in READ cycle and RF holds 0x0 -> rdata=0x12345678; WB writing x8 instead -> rdata=0x0.
- Write x3 with WB busy 4 cycles, TIMEOUT=15 -> s_rf_we_o first high cycle 5, ack cycle 6, err=0; WB busy 15+ cycles -> ack cycle 16, err=1, s_rf_we_o never high.
- s_halted_i=0, read request -> ack cycle 1, err=1, rdata unchanged; write x0=0xFFFFFFFF halted -> ack, err=0, s_rf_we_o never high; read x0 -> rdata=0.
- Reset asserted in cycle 1 of a write -> no s_rf_we_o, no ack, all outputs 0 next cycle; request deasserted after cycle 0 -> ack still produced at cycle 2.
